wb_trace_writer: RTL and testbench
==================================

# wb_trace_writer

Synthesizable writeback-trace capture block for the dual-issue core. Each cycle it samples both writeback channels, filters and orders the retired register writes, and serializes them into a single one-record-per-cycle valid/ready stream. The stream is the producer side of the golden-trace comparison format: pc, rd, wdata, cmp_flag. It sits beside the datapath's writeback stage and feeds an on-chip trace buffer or debug UART bridge.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 4
- BEGIN_PC, 32'hbfc00b14, first PC captured
- END_PC, 32'hbfc00100, PC that terminates capture
- FILTER_PC, 32'hbfc00380, base of the 8-byte PC window never traced (pc[31:3] == FILTER_PC[31:3])
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- wb0_en / wb1_en  in  1  channel 0 / channel 1 register write valid
- wb0_rd / wb1_rd  in  5  destination register
- wb0_wdata / wb1_wdata  in  32  write data
- wb0_pc / wb1_pc  in  32  instruction PC
- trace_en  in  1  confreg open_trace level, sampled per record
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_pc  out  32  record PC
- out_rd  out  5  record destination register
- out_wdata  out  32  record data
- out_flag  out  1  trace_en value at capture
- armed  out  1  state == CAPTURE
- done  out  1  state == DONE
- overflow  out  1  sticky: a record was dropped for lack of space
- drop_count  out  16  saturating count of dropped records

## Operation
- Candidate record: wbN_en && wbN_rd != 0 && wbN_pc[31:3] != FILTER_PC[31:3]. Channel 0 is always older than channel 1.
- State machine:
  - IDLE -> CAPTURE on the first candidate with pc == BEGIN_PC. That record and any younger candidate in the same cycle are captured. If channel 1 holds BEGIN_PC, channel 0 is discarded.
  - CAPTURE -> DONE when a candidate has pc == END_PC. That record is not captured. Younger records in the same cycle are discarded. An older channel-0 record in the same cycle is captured.
  - DONE is terminal until reset. The FIFO continues to drain in DONE.
- Push: the captured records (0, 1 or 2) are written in age order. Free space is DEPTH − count, using count before any same-cycle pop. If space is less than the number of records, accept the oldest ones that fit, drop the rest, set overflow, and add the number dropped to drop_count, saturating at 16'hffff.
- Pop: occurs when out_valid && out_ready. out_* show the head entry. out_valid = (count != 0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, and count_next = count + pushed − popped.

## Timing
- Reset values: out_valid 0, out_pc/out_rd/out_wdata/out_flag 0, armed 0, done 0, overflow 0, drop_count 0. State is IDLE; pointers and count are 0.
- Latency: a record pushed at clock edge N is visible on out_* after edge N. With an empty FIFO it is presented in the cycle following the writeback cycle.
- Throughput: 2 records in, 1 out per cycle. Sustained dual retire fills the FIFO at net +1 per cycle.
- out_* hold stable while out_valid && !out_ready.
- Pop and push in the same cycle are both applied.
- Asserting reset mid-operation immediately clears the FIFO, state and counters, and out_valid drops asynchronously.
- State transitions take effect at the edge following the triggering writeback cycle. armed and done are registered.

## Test plan
- Reset, then out_ready=1. Retire pc 0xbfc00b10 then 0xbfc00b14 (rd 2, wdata 0x11) on channel 0 in successive cycles -> first is ignored. Second appears one cycle later as {0xbfc00b14, 2, 0x11, flag=trace_en}; armed rises.
- While armed, drive a dual retire with ch0 {0xbfc00b18, rd 3, 0xa} and ch1 {0xbfc00b1c, rd 4, 0xb} -> two consecutive out records in that order.
- Retire rd=0, and separately pc 0xbfc00384 rd 5, while armed -> neither emitted; drop_count stays 0.
- Hold out_ready=0 with 12 cycles of dual retire at DEPTH=16 -> 16 accepted, 8 dropped; overflow=1; drop_count=8. Releasing out_ready drains exactly 16 records in order.
- Dual retire with ch0 {0xbfc00b40, rd 6} and ch1 pc=END_PC -> ch0 emitted; done=1; all later retires ignored while the FIFO finishes draining.
- Assert reset with 5 records queued -> out_valid=0 immediately. After release, armed=0, drop_count=0, and no stale records are emitted.

Source files
------------

// File: rtl/wb_trace_writer_if.sv
// Writeback-trace bus: two retire channels in, one valid/ready record stream out.
// Stream handshake: a record transfers on any clock edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, every out_* field stays unchanged.
interface wb_trace_writer_if;
  logic        wb0_en;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_wdata;
  logic [31:0] wb0_pc;
  logic        wb1_en;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_wdata;
  logic [31:0] wb1_pc;
  logic        trace_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;
  logic        out_flag;

  modport master (
    output wb0_en, wb0_rd, wb0_wdata, wb0_pc,
    output wb1_en, wb1_rd, wb1_wdata, wb1_pc,
    output trace_en, out_ready,
    input  out_valid, out_pc, out_rd, out_wdata, out_flag
  );

  modport slave (
    input  wb0_en, wb0_rd, wb0_wdata, wb0_pc,
    input  wb1_en, wb1_rd, wb1_wdata, wb1_pc,
    input  trace_en, out_ready,
    output out_valid, out_pc, out_rd, out_wdata, out_flag
  );
endinterface

// File: rtl/wb_trace_writer.sv
// Captures filtered retire records between BEGIN_PC and END_PC from two writeback
// channels and serializes them through a FIFO onto a single valid/ready stream.
module wb_trace_writer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BEGIN_PC  = 32'hbfc00b14,
  parameter logic [31:0] END_PC    = 32'hbfc00100,
  parameter logic [31:0] FILTER_PC = 32'hbfc00380
) (
  input  logic              clock,
  input  logic              reset,
  wb_trace_writer_if.slave  bus,
  output logic              armed,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       drop_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;

  // Record layout: {flag, wdata, rd, pc}
  logic [69:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic          armed_q, done_q, ovf_q;
  logic [15:0]   drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d, space_w;

  logic        cand0, cand1, take0, take1, pop;
  logic [1:0]  n_rec, n_push, n_drop;
  logic [69:0] rec0, rec1, first_rec, head;
  logic [16:0] drop_sum;

  assign cand0 = bus.wb0_en && (bus.wb0_rd != 5'd0) && (bus.wb0_pc[31:3] != FILTER_PC[31:3]);
  assign cand1 = bus.wb1_en && (bus.wb1_rd != 5'd0) && (bus.wb1_pc[31:3] != FILTER_PC[31:3]);
  assign rec0  = {bus.trace_en, bus.wb0_wdata, bus.wb0_rd, bus.wb0_pc};
  assign rec1  = {bus.trace_en, bus.wb1_wdata, bus.wb1_rd, bus.wb1_pc};

  always_comb begin
    state_d = state_q;
    take0   = 1'b0;
    take1   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cand0 && bus.wb0_pc == BEGIN_PC) begin
          state_d = S_CAPTURE;
          take0   = 1'b1;
          take1   = cand1;
        end else if (cand1 && bus.wb1_pc == BEGIN_PC) begin
          state_d = S_CAPTURE;
          take1   = 1'b1;
        end
      end
      S_CAPTURE: begin
        // The END_PC record itself is never captured; anything younger is discarded.
        if (cand0 && bus.wb0_pc == END_PC) begin
          state_d = S_DONE;
        end else begin
          take0 = cand0;
          if (cand1 && bus.wb1_pc == END_PC) state_d = S_DONE;
          else                               take1   = cand1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    n_rec     = {1'b0, take0} + {1'b0, take1};
    space_w   = (AW+1)'(DEPTH) - count_q;
    n_push    = (space_w < (AW+1)'(n_rec)) ? space_w[1:0] : n_rec;
    n_drop    = n_rec - n_push;
    first_rec = take0 ? rec0 : rec1;
    pop       = bus.out_valid && bus.out_ready;
    count_d   = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
    drop_sum  = {1'b0, drop_q} + 17'(n_drop);
    drop_d    = drop_sum[16] ? 16'hffff : drop_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= (state_d == S_CAPTURE);
      done_q   <= (state_d == S_DONE);
      ovf_q    <= ovf_q | (n_drop != 2'd0);
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
    end
  end

  // Only the oldest accepted record can land in slot 0; slot 1 is always channel 1.
  always_ff @(posedge clock) begin
    if (n_push != 2'd0) mem_q[wr_ptr_q] <= first_rec;
    if (n_push == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= rec1;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = bus.out_valid ? head[31:0]  : 32'd0;
  assign bus.out_rd    = bus.out_valid ? head[36:32] : 5'd0;
  assign bus.out_wdata = bus.out_valid ? head[68:37] : 32'd0;
  assign bus.out_flag  = bus.out_valid ? head[69]    : 1'b0;

  assign armed      = armed_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_wb_trace_writer.sv
// Directed plus randomized bench for wb_trace_writer against a queue-based trace model.
module tb_wb_trace_writer;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] BEGIN_PC  = 32'hbfc00b14;
  localparam logic [31:0] END_PC    = 32'hbfc00100;
  localparam logic [31:0] FILTER_PC = 32'hbfc00380;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        armed, done, overflow;
  logic [15:0] drop_count;

  wb_trace_writer_if bus();

  wb_trace_writer #(
    .DEPTH(DEPTH), .BEGIN_PC(BEGIN_PC), .END_PC(END_PC), .FILTER_PC(FILTER_PC)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .armed(armed), .done(done), .overflow(overflow), .drop_count(drop_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  logic [69:0] exp_q[$];
  bit          m_began, m_ended, m_ovf;
  int          m_drops;
  int          total = 0;
  int          bad   = 0;
  int          dut_pops;

  function automatic logic [69:0] mk(logic f, logic [31:0] w, logic [4:0] rd, logic [31:0] pc);
    return {f, w, rd, pc};
  endfunction

  function automatic bit is_cand(logic en, logic [4:0] rd, logic [31:0] pc);
    return en && (rd != 5'd0) && ((pc >> 3) != (FILTER_PC >> 3));
  endfunction

  task automatic check(string tag, logic [69:0] got, logic [69:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_began = 0;
    m_ended = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  // One clock edge of the trace rules applied to the inputs currently driven.
  task automatic model_edge();
    logic [69:0] recs[$];
    logic [69:0] r0, r1;
    bit c0, c1, do_pop;
    int space, nd;
    r0 = mk(bus.trace_en, bus.wb0_wdata, bus.wb0_rd, bus.wb0_pc);
    r1 = mk(bus.trace_en, bus.wb1_wdata, bus.wb1_rd, bus.wb1_pc);
    c0 = is_cand(bus.wb0_en, bus.wb0_rd, bus.wb0_pc);
    c1 = is_cand(bus.wb1_en, bus.wb1_rd, bus.wb1_pc);
    do_pop = (exp_q.size() != 0) && bus.out_ready;
    if (!m_began) begin
      if (c0 && bus.wb0_pc == BEGIN_PC) begin
        m_began = 1;
        recs.push_back(r0);
        if (c1) recs.push_back(r1);
      end else if (c1 && bus.wb1_pc == BEGIN_PC) begin
        m_began = 1;
        recs.push_back(r1);
      end
    end else if (!m_ended) begin
      if (c0 && bus.wb0_pc == END_PC) m_ended = 1;
      else begin
        if (c0) recs.push_back(r0);
        if (c1 && bus.wb1_pc == END_PC) m_ended = 1;
        else if (c1) recs.push_back(r1);
      end
    end
    space = DEPTH - exp_q.size();
    nd = 0;
    foreach (recs[i]) begin
      if (space > 0) begin
        exp_q.push_back(recs[i]);
        space--;
      end else nd++;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (nd > 0) m_ovf = 1;
    m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
  endtask

  task automatic compare_all();
    check("out_valid", 70'(bus.out_valid), 70'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("out_rec", {bus.out_flag, bus.out_wdata, bus.out_rd, bus.out_pc}, exp_q[0]);
    check("armed", 70'(armed), 70'(m_began && !m_ended));
    check("done", 70'(done), 70'(m_ended));
    check("overflow", 70'(overflow), 70'(m_ovf));
    check("drop_count", 70'(drop_count), 70'(m_drops[15:0]));
  endtask

  // driver tasks
  task automatic set0(logic en, logic [4:0] rd, logic [31:0] w, logic [31:0] pc);
    bus.wb0_en = en; bus.wb0_rd = rd; bus.wb0_wdata = w; bus.wb0_pc = pc;
  endtask

  task automatic set1(logic en, logic [4:0] rd, logic [31:0] w, logic [31:0] pc);
    bus.wb1_en = en; bus.wb1_rd = rd; bus.wb1_wdata = w; bus.wb1_pc = pc;
  endtask

  task automatic idle();
    set0(1'b0, 5'd0, 32'd0, 32'd0);
    set1(1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic step();
    if (bus.out_valid && bus.out_ready) dut_pops++;
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic drain(int max_cycles);
    bus.out_ready = 1'b1;
    idle();
    for (int i = 0; i < max_cycles; i++) step();
    check("drained", 70'(bus.out_valid), 70'(0));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 7) == 0) pc = FILTER_PC + {$urandom_range(0, 1), 2'b00};
    else pc = 32'hbfc00000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    if (pc == END_PC) pc = pc + 32'd4;
    return pc;
  endfunction

  task automatic rand_cycle();
    set0(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, rand_pc());
    set1(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, rand_pc());
    bus.trace_en  = 1'($urandom_range(0, 1));
    bus.out_ready = 1'($urandom_range(0, 1));
    step();
  endtask

  initial begin
    dut_pops = 0;
    idle();
    bus.trace_en  = 1'b1;
    bus.out_ready = 1'b0;
    model_reset();

    // reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 70'(bus.out_valid), 70'(0));
    check("rst_out", {bus.out_flag, bus.out_wdata, bus.out_rd, bus.out_pc}, 70'(0));
    check("rst_armed", 70'(armed), 70'(0));
    check("rst_done", 70'(done), 70'(0));
    check("rst_ovf", 70'(overflow), 70'(0));
    check("rst_drops", 70'(drop_count), 70'(0));
    @(negedge clock);
    reset = 1'b0;

    // arming on BEGIN_PC
    bus.out_ready = 1'b1;
    bus.trace_en  = 1'($urandom_range(0, 1));
    set0(1'b1, 5'd2, 32'h11, 32'hbfc00b10);
    step();
    check("pre_begin_valid", 70'(bus.out_valid), 70'(0));
    set0(1'b1, 5'd2, 32'h11, BEGIN_PC);
    step();
    check("begin_pc", 70'(bus.out_pc), 70'(32'hbfc00b14));
    check("begin_rd", 70'(bus.out_rd), 70'(2));
    check("armed_rise", 70'(armed), 70'(1));

    // dual retire ordering
    set0(1'b1, 5'd3, 32'ha, 32'hbfc00b18);
    set1(1'b1, 5'd4, 32'hb, 32'hbfc00b1c);
    step();
    check("dual_first", 70'(bus.out_pc), 70'(32'hbfc00b18));
    idle();
    step();
    check("dual_second", 70'(bus.out_pc), 70'(32'hbfc00b1c));
    check("dual_second_wd", 70'(bus.out_wdata), 70'(32'hb));

    // rd==0 and filtered window
    set0(1'b1, 5'd0, 32'h55, 32'hbfc00b20);
    step();
    set0(1'b1, 5'd5, 32'h66, 32'hbfc00384);
    step();
    idle();
    step();
    check("filtered_none", 70'(bus.out_valid), 70'(0));
    check("filtered_drops", 70'(drop_count), 70'(0));

    // overflow with stalled consumer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set0(1'b1, 5'($urandom_range(1, 31)), $urandom, 32'hbfc00c00 + 32'(i * 8));
      set1(1'b1, 5'($urandom_range(1, 31)), $urandom, 32'hbfc00c04 + 32'(i * 8));
      step();
    end
    check("ovf_flag", 70'(overflow), 70'(1));
    check("ovf_drops", 70'(drop_count), 70'(8));
    dut_pops = 0;
    drain(40);
    check("ovf_drain_count", 70'(dut_pops), 70'(16));

    // randomized traffic while armed
    for (int i = 0; i < 400; i++) rand_cycle();
    drain(40);

    // END_PC on channel 1
    set0(1'b1, 5'd6, 32'h77, 32'hbfc00b40);
    set1(1'b1, 5'd7, 32'h88, END_PC);
    step();
    check("end_ch0_pc", 70'(bus.out_pc), 70'(32'hbfc00b40));
    check("end_done", 70'(done), 70'(1));
    check("end_armed", 70'(armed), 70'(0));
    for (int i = 0; i < 20; i++) rand_cycle();
    set0(1'b1, 5'd9, 32'h99, BEGIN_PC);
    step();
    drain(10);

    // asynchronous reset with records queued
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    set0(1'b1, 5'd1, 32'h1, BEGIN_PC);
    set1(1'b1, 5'd2, 32'h2, 32'hbfc00b18);
    step();
    set0(1'b1, 5'd3, 32'h3, 32'hbfc00b1c);
    set1(1'b1, 5'd4, 32'h4, 32'hbfc00b20);
    step();
    set0(1'b1, 5'd5, 32'h5, 32'hbfc00b24);
    set1(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    check("queued_five", 70'(exp_q.size() == 5 && bus.out_valid), 70'(1));
    idle();
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 70'(bus.out_valid), 70'(0));
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_armed", 70'(armed), 70'(0));
    check("post_rst_drops", 70'(drop_count), 70'(0));
    check("post_rst_valid", 70'(bus.out_valid), 70'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
